// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot frame pipeline: engine widths,
// default frame geometry and the pixel scanner state encoding.
package mandel_pkg;
    localparam int HBI        = 32;
    localparam int CW         = 12;
    localparam int DEF_WIDTH  = 640;
    localparam int DEF_HEIGHT = 480;
    localparam int DEF_AW     = 19;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_WRITE  = 2'd3
    } scan_state_e;
endpackage

// File: rtl/pixel_counter.sv
// Raster-order x/y counter with a running linear address, so the frame-buffer
// address never needs a y*WIDTH multiply.
module pixel_counter #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int CW     = 12,
    parameter int AW     = 19
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic [AW-1:0] addr,
    output logic          last
);
    logic last_x;
    logic last_y;

    assign last_x = (x == CW'(WIDTH - 1));
    assign last_y = (y == CW'(HEIGHT - 1));
    assign last   = last_x && last_y;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (clr) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (inc) begin
            if (last_x) begin
                x <= '0;
                y <= y + CW'(1);
            end else begin
                x <= x + CW'(1);
            end
            addr <= addr + AW'(1);
        end
    end
endmodule

// File: rtl/pixel_scanner.sv
// Frame sequencer: walks every pixel in raster order, launches the escape-time
// engine per pixel and forwards {addr, iteration} to the frame buffer.
module pixel_scanner
    import mandel_pkg::*;
#(
    parameter int WIDTH  = mandel_pkg::DEF_WIDTH,
    parameter int HEIGHT = mandel_pkg::DEF_HEIGHT,
    parameter int CW     = mandel_pkg::CW,
    parameter int HBI    = mandel_pkg::HBI,
    parameter int AW     = mandel_pkg::DEF_AW
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           go,
    input  logic           abort,
    output logic           pg_start,
    output logic [CW-1:0]  pg_x,
    output logic [CW-1:0]  pg_y,
    input  logic           pg_ready,
    input  logic [HBI-1:0] pg_iter,
    output logic           wr_valid,
    input  logic           wr_ready,
    output logic [AW-1:0]  wr_addr,
    output logic [HBI-1:0] wr_data,
    output logic           busy,
    output logic           frame_done
);
    scan_state_e state, state_nx;
    logic        accept;
    logic        start_frame;
    logic        capture;
    logic        last_pix;

    pixel_counter #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .CW    (CW),
        .AW    (AW)
    ) u_cnt (
        .CLK (CLK),
        .RST (RST),
        .clr (start_frame),
        .inc (accept && !last_pix),
        .x   (pg_x),
        .y   (pg_y),
        .addr(wr_addr),
        .last(last_pix)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // abort outranks every other transition once a frame is in flight
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (go && !abort) state_nx = ST_LAUNCH;
            ST_LAUNCH: state_nx = abort ? ST_IDLE : ST_WAIT;
            ST_WAIT:   if (abort) state_nx = ST_IDLE;
                       else if (pg_ready) state_nx = ST_WRITE;
            ST_WRITE:  if (abort) state_nx = ST_IDLE;
                       else if (wr_ready) state_nx = last_pix ? ST_IDLE : ST_LAUNCH;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Gating with abort keeps a same-cycle abort from completing a handshake.
    always_comb begin
        pg_start    = (state == ST_LAUNCH) && !abort;
        wr_valid    = (state == ST_WRITE) && !abort;
        busy        = (state != ST_IDLE);
        accept      = wr_valid && wr_ready;
        start_frame = (state == ST_IDLE) && go && !abort;
        capture     = (state == ST_WAIT) && pg_ready && !abort;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            if (capture) wr_data <= pg_iter;
            frame_done <= accept && last_pix;
        end
    end
endmodule

// File: tb/tb_pixel_scanner.sv
// Directed bench for pixel_scanner: engine models with coordinate-dependent
// latency, scoreboard queues of expected writes, and timing/hold monitors.
module tb_pixel_scanner;
    localparam int CW  = 12;
    localparam int HBI = 32;
    localparam int AW  = 19;
    localparam int WA  = 4;
    localparam int HA  = 3;

    typedef struct {
        logic [AW-1:0]  addr;
        logic [HBI-1:0] data;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic go_a = 1'b0, abort_a = 1'b0, wr_ready_a = 1'b1;
    logic pg_start_a, pg_ready_a, wr_valid_a, busy_a, frame_done_a;
    logic [CW-1:0]  pg_x_a, pg_y_a;
    logic [HBI-1:0] pg_iter_a, wr_data_a;
    logic [AW-1:0]  wr_addr_a;

    logic go_b = 1'b0, abort_b = 1'b0, wr_ready_b = 1'b1;
    logic pg_start_b, pg_ready_b, wr_valid_b, busy_b, frame_done_b;
    logic [CW-1:0]  pg_x_b, pg_y_b;
    logic [HBI-1:0] pg_iter_b, wr_data_b;
    logic [AW-1:0]  wr_addr_b;

    pixel_scanner #(.WIDTH(WA), .HEIGHT(HA), .CW(CW), .HBI(HBI), .AW(AW)) u_dut_a (
        .CLK(CLK), .RST(RST), .go(go_a), .abort(abort_a),
        .pg_start(pg_start_a), .pg_x(pg_x_a), .pg_y(pg_y_a),
        .pg_ready(pg_ready_a), .pg_iter(pg_iter_a),
        .wr_valid(wr_valid_a), .wr_ready(wr_ready_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .busy(busy_a), .frame_done(frame_done_a));

    pixel_scanner #(.WIDTH(2), .HEIGHT(2), .CW(CW), .HBI(HBI), .AW(AW)) u_dut_b (
        .CLK(CLK), .RST(RST), .go(go_b), .abort(abort_b),
        .pg_start(pg_start_b), .pg_x(pg_x_b), .pg_y(pg_y_b),
        .pg_ready(pg_ready_b), .pg_iter(pg_iter_b),
        .wr_valid(wr_valid_b), .wr_ready(wr_ready_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .busy(busy_b), .frame_done(frame_done_b));

    // Engine A: latency and result both x+y; ready stays high until the next start.
    logic [HBI-1:0] eng_cnt_a, eng_res_a;
    logic           eng_act_a;
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            eng_act_a <= 1'b0;
            eng_cnt_a <= '0;
            eng_res_a <= '0;
        end else if (pg_start_a) begin
            eng_act_a <= 1'b1;
            eng_cnt_a <= HBI'(pg_x_a) + HBI'(pg_y_a);
            eng_res_a <= HBI'(pg_x_a) + HBI'(pg_y_a);
        end else if (eng_act_a && eng_cnt_a != '0) begin
            eng_cnt_a <= eng_cnt_a - HBI'(1);
        end
    end
    assign pg_ready_a = eng_act_a && (eng_cnt_a == '0);
    assign pg_iter_a  = eng_res_a;

    // Engine B: max_iterations = 0, ready from the first WAIT cycle with result 0.
    logic eng_act_b;
    always @(posedge CLK or posedge RST) begin
        if (RST)             eng_act_b <= 1'b0;
        else if (pg_start_b) eng_act_b <= 1'b1;
    end
    assign pg_ready_b = eng_act_b;
    assign pg_iter_b  = '0;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    exp_t q_a[$], q_b[$];
    int cyc_a = 0, cyc_b = 0, acc_a = 0, acc_b = 0, fd_a = 0, fd_b = 0;
    int st_a = -100, st_b = -1, lat_a = 0;
    logic pv_a = 1'b0, pacc_a = 1'b0;
    logic [AW-1:0]  paddr_a = '0;
    logic [HBI-1:0] pdata_a = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_frame_a();
        for (int y = 0; y < HA; y++)
            for (int x = 0; x < WA; x++)
                q_a.push_back('{addr: AW'(y * WA + x), data: HBI'(x + y)});
    endtask

    task automatic mon_a();
        exp_t e;
        forever begin
            @(negedge CLK);
            cyc_a++;
            if (RST) begin
                pv_a = 1'b0; pacc_a = 1'b0; st_a = -100;
            end else begin
                if (pg_start_a) begin
                    chk("start_gap_a", 64'((cyc_a - st_a) >= 3), 64'd1);
                    if (q_a.size() == 0) chk("sb_empty_start_a", 64'd1, 64'd0);
                    else begin
                        chk("pg_x_a", 64'(pg_x_a), 64'(int'(q_a[0].addr) % WA));
                        chk("pg_y_a", 64'(pg_y_a), 64'(int'(q_a[0].addr) / WA));
                        lat_a = int'(q_a[0].addr) % WA + int'(q_a[0].addr) / WA;
                    end
                    st_a = cyc_a;
                end
                if (pv_a && !pacc_a && !abort_a) begin
                    chk("hold_vld_a", 64'(wr_valid_a), 64'd1);
                    chk("hold_addr_a", 64'(wr_addr_a), 64'(paddr_a));
                    chk("hold_data_a", 64'(wr_data_a), 64'(pdata_a));
                end else if (wr_valid_a) begin
                    chk("wr_latency_a", 64'(cyc_a - st_a), 64'(lat_a + 2));
                end
                if (wr_valid_a && wr_ready_a) begin
                    if (q_a.size() == 0) chk("sb_empty_wr_a", 64'd1, 64'd0);
                    else begin
                        e = q_a.pop_front();
                        chk("wr_addr_a", 64'(wr_addr_a), 64'(e.addr));
                        chk("wr_data_a", 64'(wr_data_a), 64'(e.data));
                    end
                    acc_a++;
                end
                if (frame_done_a) begin
                    fd_a++;
                    chk("fdone_pending_a", 64'(q_a.size()), 64'd0);
                end
                pv_a = wr_valid_a; pacc_a = wr_valid_a && wr_ready_a;
                paddr_a = wr_addr_a; pdata_a = wr_data_a;
            end
        end
    endtask

    task automatic mon_b();
        exp_t e;
        forever begin
            @(negedge CLK);
            cyc_b++;
            if (!RST) begin
                if (pg_start_b) begin
                    if (st_b >= 0) chk("start_period_b", 64'(cyc_b - st_b), 64'd3);
                    st_b = cyc_b;
                end
                if (wr_valid_b && wr_ready_b) begin
                    if (q_b.size() == 0) chk("sb_empty_wr_b", 64'd1, 64'd0);
                    else begin
                        e = q_b.pop_front();
                        chk("wr_addr_b", 64'(wr_addr_b), 64'(e.addr));
                        chk("wr_data_b", 64'(wr_data_b), 64'(e.data));
                    end
                    acc_b++;
                end
                if (frame_done_b) begin
                    fd_b++;
                    st_b = -1;
                end
            end
        end
    endtask

    task automatic wait_idle_a(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge CLK);
            if (!busy_a) break;
        end
        chk("idle_timeout_a", 64'(busy_a), 64'd0);
    endtask

    task automatic wait_start_a(input int px, input int py, input int lim);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < lim && !hit; i++) begin
            @(negedge CLK);
            hit = pg_start_a && (int'(pg_x_a) == px) && (int'(pg_y_a) == py);
        end
        chk("start_timeout_a", 64'(hit), 64'd1);
    endtask

    task automatic wait_vld_a(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge CLK);
            if (wr_valid_a) break;
        end
        chk("valid_timeout_a", 64'(wr_valid_a), 64'd1);
    endtask

    task automatic go_pulse_a();
        tick(); go_a = 1'b1;
        tick(); go_a = 1'b0;
    endtask

    int a0, f0;

    initial begin
        fork
            mon_a();
            mon_b();
        join_none

        repeat (2) @(negedge CLK);
        chk("rst_start", 64'(pg_start_a), 64'd0);
        chk("rst_x", 64'(pg_x_a), 64'd0);
        chk("rst_y", 64'(pg_y_a), 64'd0);
        chk("rst_valid", 64'(wr_valid_a), 64'd0);
        chk("rst_addr", 64'(wr_addr_a), 64'd0);
        chk("rst_data", 64'(wr_data_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_fdone", 64'(frame_done_a), 64'd0);
        tick(); RST = 1'b0;
        tick();

        // go and abort together in IDLE: stay idle
        go_a = 1'b1; abort_a = 1'b1;
        tick(); go_a = 1'b0; abort_a = 1'b0;
        @(negedge CLK);
        chk("go_abort_idle", 64'(busy_a), 64'd0);

        // full 4x3 frame, latency x+y
        push_frame_a(); a0 = acc_a; f0 = fd_a;
        go_pulse_a();
        wait_idle_a(400);
        chk("t1_writes", 64'(acc_a - a0), 64'd12);
        chk("t1_fdone", 64'(fd_a - f0), 64'd1);

        // 2x2 frame with zero-iteration engine
        for (int i = 0; i < 4; i++) q_b.push_back('{addr: AW'(i), data: '0});
        tick(); go_b = 1'b1;
        tick(); go_b = 1'b0;
        for (int i = 0; i < 100 && busy_b; i++) @(negedge CLK);
        chk("t2_idle_b", 64'(busy_b), 64'd0);
        chk("t2_writes_b", 64'(acc_b), 64'd4);
        chk("t2_fdone_b", 64'(fd_b), 64'd1);

        // backpressure on pixel 2, with go pulsed while busy
        push_frame_a(); a0 = acc_a; f0 = fd_a;
        go_pulse_a();
        wait_start_a(2, 0, 100);
        tick(); wr_ready_a = 1'b0;
        wait_vld_a(50);
        go_pulse_a();
        repeat (3) tick();
        wr_ready_a = 1'b1;
        wait_idle_a(400);
        chk("t3_writes", 64'(acc_a - a0), 64'd12);
        chk("t3_fdone", 64'(fd_a - f0), 64'd1);
        chk("t3_restart_ignored", 64'(q_a.size()), 64'd0);

        // async reset mid-WAIT on pixel 5, then restart from addr 0
        push_frame_a();
        go_pulse_a();
        wait_start_a(1, 1, 200);
        tick(); RST = 1'b1;
        #1;
        chk("t5_busy", 64'(busy_a), 64'd0);
        chk("t5_valid", 64'(wr_valid_a), 64'd0);
        chk("t5_start", 64'(pg_start_a), 64'd0);
        chk("t5_x", 64'(pg_x_a), 64'd0);
        chk("t5_y", 64'(pg_y_a), 64'd0);
        chk("t5_addr", 64'(wr_addr_a), 64'd0);
        chk("t5_data", 64'(wr_data_a), 64'd0);
        chk("t5_fdone", 64'(frame_done_a), 64'd0);
        q_a.delete();
        tick(); RST = 1'b0;
        push_frame_a(); a0 = acc_a; f0 = fd_a;
        go_pulse_a();
        wait_idle_a(400);
        chk("t5_writes", 64'(acc_a - a0), 64'd12);
        chk("t5_fdone2", 64'(fd_a - f0), 64'd1);

        // abort in WRITE with wr_ready in the same cycle
        push_frame_a(); a0 = acc_a; f0 = fd_a;
        go_pulse_a();
        wait_start_a(3, 0, 200);
        tick(); wr_ready_a = 1'b0;
        wait_vld_a(50);
        tick(); abort_a = 1'b1; wr_ready_a = 1'b1;
        @(negedge CLK);
        chk("t6_abort_valid", 64'(wr_valid_a), 64'd0);
        tick(); abort_a = 1'b0;
        @(negedge CLK);
        chk("t6_idle", 64'(busy_a), 64'd0);
        repeat (5) @(negedge CLK);
        chk("t6_writes", 64'(acc_a - a0), 64'd3);
        chk("t6_no_fdone", 64'(fd_a - f0), 64'd0);
        chk("t6_no_start", 64'(busy_a), 64'd0);
        q_a.delete();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
